// File: rtl/single_clock_fwft_fifo.sv
// single_clock_fwft_fifo: single-clock FIFO with registered-read or first-word-fall-through output
module single_clock_fwft_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 512,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_full,
    output logic                       wr_almost_full,
    output logic                       wr_overflow,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       rd_empty,
    output logic                       rd_almost_empty,
    output logic                       rd_underflow,
    output logic [$clog2(DEPTH):0]     size
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AF_LVL   = (ADDR_BITS + 1)'(AF_THRESH);
    localparam logic [ADDR_BITS:0] AE_LVL   = (ADDR_BITS + 1)'(AE_THRESH);
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "single_clock_fwft_fifo: DEPTH must be a power of two >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1 || AE_THRESH < 1 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
        $fatal(1, "single_clock_fwft_fifo: thresholds must lie in 1..DEPTH-1");
    end
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]   size_nxt;
    logic                 push, pop;
    always_comb begin
        push     = wr_en && !wr_full;
        pop      = rd_en && !rd_empty;
        size_nxt = size + (ADDR_BITS + 1)'(push) - (ADDR_BITS + 1)'(pop);
    end
    // flags are derived from the next size so they move in the same cycle as size
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            size            <= '0;
            wr_full         <= 1'b0;
            wr_almost_full  <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            wr_overflow     <= 1'b0;
            rd_underflow    <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr + ADDR_BITS'(push);
            rd_ptr          <= rd_ptr + ADDR_BITS'(pop);
            size            <= size_nxt;
            wr_full         <= size_nxt == FULL_LVL;
            wr_almost_full  <= size_nxt >= AF_LVL;
            rd_empty        <= size_nxt == '0;
            rd_almost_empty <= size_nxt <= AE_LVL;
            wr_overflow     <= wr_en && wr_full;
            rd_underflow    <= rd_en && rd_empty;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= wr_data;
    end
    if (FWFT != 0) begin : g_fwft
        always_comb begin
            rd_data  = rd_empty ? '0 : mem[rd_ptr];
            rd_valid = !rd_empty;
        end
    end else begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= pop;
                if (pop) rd_data <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_single_clock_fwft_fifo.sv
// tb_single_clock_fwft_fifo: both read modes driven in lockstep and checked against a queue model
module tb_single_clock_fwft_fifo;
    logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       f0, af0, ov0, rv0, e0, ae0, ud0;
    logic       f1, af1, ov1, rv1, e1, ae1, ud1;
    logic [7:0] rdd0, rdd1;
    logic [3:0] sz0, sz1;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] q[$];
    logic [7:0] m_d0 = '0;
    logic       m_v0 = 1'b0, m_ov = 1'b0, m_ud = 1'b0;

    single_clock_fwft_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) d0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f0),
        .wr_almost_full(af0), .wr_overflow(ov0), .rd_en(rd_en), .rd_data(rdd0), .rd_valid(rv0),
        .rd_empty(e0), .rd_almost_empty(ae0), .rd_underflow(ud0), .size(sz0));
    single_clock_fwft_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) d1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f1),
        .wr_almost_full(af1), .wr_overflow(ov1), .rd_en(rd_en), .rd_data(rdd1), .rd_valid(rv1),
        .rd_empty(e1), .rd_almost_empty(ae1), .rd_underflow(ud1), .size(sz1));

    always #5 clk = ~clk;

    // one clock of stimulus; the model applies the occupancy rules to a queue using pre-edge occupancy
    task automatic tick(input logic w, input logic [7:0] d, input logic r);
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        if (!rst_n) begin
            q.delete(); m_d0 = '0; m_v0 = 1'b0; m_ov = 1'b0; m_ud = 1'b0;
        end else begin
            m_ov = w && q.size() == 8;
            m_ud = r && q.size() == 0;
            m_v0 = r && q.size() > 0;
            if (m_v0) m_d0 = q.pop_front();
            if (w && !m_ov) q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(1'b1, 8'hAA, 1'b1);
        tick(1'b1, 8'hBB, 1'b1);
        n_cmp++;
        if ({sz0, e0, ae0, f0, af0, ov0, ud0, rv0} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_flags: got sz=%0d e=%b ae=%b f=%b af=%b ov=%b ud=%b v=%b want 0 1 1 0 0 0 0 0",
                sz0, e0, ae0, f0, af0, ov0, ud0, rv0);
        end
        n_cmp++;
        if ({rdd0, rdd1, rv1, sz1, e1} !== {8'h00, 8'h00, 1'b0, 4'd0, 1'b1}) begin
            n_bad++; $display("FAIL reset_data: got rd0=%h rd1=%h v1=%b sz1=%0d e1=%b want 00 00 0 0 1", rdd0, rdd1, rv1, sz1, e1);
        end
        rst_n = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 8'h11 + 8'(i), 1'b0);
            n_cmp++;
            if (int'(sz0) !== i + 1 || af0 !== (i + 1 >= 6) || e0 !== 1'b0 || f0 !== (i == 7)) begin
                n_bad++; $display("FAIL fill_%0d: got sz=%0d af=%b e=%b f=%b want sz=%0d af=%b e=0 f=%b",
                    i, sz0, af0, e0, f0, i + 1, i + 1 >= 6, i == 7);
            end
        end
        tick(1'b1, 8'h99, 1'b0);
        n_cmp++;
        if (ov0 !== 1'b1 || sz0 !== 4'd8 || f0 !== 1'b1) begin
            n_bad++; $display("FAIL overflow_pulse: got ov=%b sz=%0d f=%b want 1 8 1", ov0, sz0, f0);
        end
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (ov0 !== 1'b0 || sz0 !== 4'd8) begin
            n_bad++; $display("FAIL overflow_once: got ov=%b sz=%0d want 0 8", ov0, sz0);
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rv1 !== 1'b1 || rdd1 !== 8'h11 + 8'(i)) begin
                n_bad++; $display("FAIL fwft_head_%0d: got v=%b d=%h want 1 %h", i, rv1, rdd1, 8'h11 + 8'(i));
            end
            tick(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (rv0 !== 1'b1 || rdd0 !== 8'h11 + 8'(i) || int'(sz0) !== 7 - i || ae0 !== (7 - i <= 2)) begin
                n_bad++; $display("FAIL drain_%0d: got v=%b d=%h sz=%0d ae=%b want 1 %h %0d %b",
                    i, rv0, rdd0, sz0, ae0, 8'h11 + 8'(i), 7 - i, 7 - i <= 2);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (rv0 !== 1'b0 || rdd0 !== 8'h18 || e0 !== 1'b1) begin
            n_bad++; $display("FAIL valid_one_cycle: got v=%b d=%h e=%b want 0 18 1", rv0, rdd0, e0);
        end
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (ud0 !== 1'b1 || rv0 !== 1'b0 || ud1 !== 1'b1 || rv1 !== 1'b0) begin
            n_bad++; $display("FAIL underflow: got ud=%b v=%b ud1=%b v1=%b want 1 0 1 0", ud0, rv0, ud1, rv1);
        end
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (ud0 !== 1'b0) begin
            n_bad++; $display("FAIL underflow_once: got %b want 0", ud0);
        end
    endtask

    task automatic test_fwft;
        tick(1'b1, 8'hAB, 1'b1);
        n_cmp++;
        if (e1 !== 1'b0 || rv1 !== 1'b1 || rdd1 !== 8'hAB || ud1 !== 1'b1 || sz1 !== 4'd1) begin
            n_bad++; $display("FAIL fwft_fall_through: got e=%b v=%b d=%h ud=%b sz=%0d want 0 1 ab 1 1", e1, rv1, rdd1, ud1, sz1);
        end
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (rv1 !== 1'b1 || rdd1 !== 8'hAB || rv0 !== 1'b0) begin
            n_bad++; $display("FAIL fwft_hold: got v1=%b d1=%h v0=%b want 1 ab 0", rv1, rdd1, rv0);
        end
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (rv0 !== 1'b1 || rdd0 !== 8'hAB || rv1 !== 1'b0 || e1 !== 1'b1) begin
            n_bad++; $display("FAIL fwft_ack: got v0=%b d0=%h v1=%b e1=%b want 1 ab 0 1", rv0, rdd0, rv1, e1);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        logic [7:0] v;
        for (int i = 0; i < 3; i++) begin
            v = 8'($urandom);
            exp.push_back(v);
            tick(1'b1, v, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (rdd1 !== exp[0]) begin
                n_bad++; $display("FAIL b2b_head_%0d: got %h want %h", i, rdd1, exp[0]);
            end
            v = 8'($urandom);
            exp.push_back(v);
            tick(1'b1, v, 1'b1);
            n_cmp++;
            if (sz0 !== 4'd3 || sz1 !== 4'd3 || rv0 !== 1'b1 || rdd0 !== exp[0]) begin
                n_bad++; $display("FAIL b2b_%0d: got sz=%0d sz1=%0d v=%b d=%h want 3 3 1 %h", i, sz0, sz1, rv0, rdd0, exp[0]);
            end
            void'(exp.pop_front());
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (rdd0 !== exp[0]) begin
                n_bad++; $display("FAIL b2b_tail_%0d: got %h want %h", i, rdd0, exp[0]);
            end
            void'(exp.pop_front());
        end
    endtask

    task automatic test_thresholds;
        for (int i = 1; i <= 7; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            n_cmp++;
            if (int'(sz0) !== i || af0 !== (i >= 6) || af1 !== (i >= 6) || ae0 !== (i <= 2)) begin
                n_bad++; $display("FAIL af_size_%0d: got sz=%0d af=%b af1=%b ae=%b want %0d %b %b %b",
                    i, sz0, af0, af1, ae0, i, i >= 6, i >= 6, i <= 2);
            end
        end
        for (int i = 6; i >= 0; i--) begin
            tick(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (int'(sz0) !== i || ae0 !== (i <= 2) || ae1 !== (i <= 2) || af0 !== (i >= 6)) begin
                n_bad++; $display("FAIL ae_size_%0d: got sz=%0d ae=%b ae1=%b af=%b want %0d %b %b %b",
                    i, sz0, ae0, ae1, af0, i, i <= 2, i <= 2, i >= 6);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'hC0 + 8'(i), 1'b0);
        rst_n = 1'b0;
        tick(1'b1, 8'hEE, 1'b1);
        rst_n = 1'b1;
        n_cmp++;
        if (sz0 !== 4'd0 || e0 !== 1'b1 || rv0 !== 1'b0 || ov0 !== 1'b0 || ud0 !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got sz=%0d e=%b v=%b ov=%b ud=%b want 0 1 0 0 0", sz0, e0, rv0, ov0, ud0);
        end
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b1, 8'h5B, 1'b1);
        n_cmp++;
        if (rdd0 !== 8'h5A || rv0 !== 1'b1 || sz0 !== 4'd1) begin
            n_bad++; $display("FAIL post_reset_1: got d=%h v=%b sz=%0d want 5a 1 1", rdd0, rv0, sz0);
        end
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (rdd0 !== 8'h5B || rv0 !== 1'b1 || e0 !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_2: got d=%h v=%b e=%b want 5b 1 1", rdd0, rv0, e0);
        end
    endtask

    task automatic test_random;
        int pw, pr, n;
        for (int k = 0; k < 600; k++) begin
            if (k % 40 == 0) begin pw = $urandom_range(15, 85); pr = $urandom_range(15, 85); end
            rst_n = $urandom_range(0, 99) != 0;
            tick($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
            n = q.size();
            n_cmp++;
            if (int'(sz0) !== n || int'(sz1) !== n || f0 !== (n == 8) || af0 !== (n >= 6) || e0 !== (n == 0) || ae0 !== (n <= 2)) begin
                n_bad++; $display("FAIL rnd_level_%0d: got sz=%0d sz1=%0d f=%b af=%b e=%b ae=%b want sz=%0d", k, sz0, sz1, f0, af0, e0, ae0, n);
            end
            n_cmp++;
            if (ov0 !== m_ov || ud0 !== m_ud || ov1 !== m_ov || ud1 !== m_ud) begin
                n_bad++; $display("FAIL rnd_pulse_%0d: got ov=%b ud=%b ov1=%b ud1=%b want %b %b", k, ov0, ud0, ov1, ud1, m_ov, m_ud);
            end
            n_cmp++;
            if (rv0 !== m_v0 || rdd0 !== m_d0) begin
                n_bad++; $display("FAIL rnd_reg_%0d: got v=%b d=%h want %b %h", k, rv0, rdd0, m_v0, m_d0);
            end
            n_cmp++;
            if (rv1 !== (n > 0) || (n > 0 && rdd1 !== q[0])) begin
                n_bad++; $display("FAIL rnd_fwft_%0d: got v=%b d=%h want %b %h", k, rv1, rdd1, n > 0, n > 0 ? q[0] : 8'h00);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_fwft;
        test_back_to_back;
        test_thresholds;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
